piso_ser: RTL and testbench

PISO_SER -- requirements
Module: piso_ser

---
 rtl/piso_ser_pkg.sv | 15 +
 rtl/piso_ser_if.sv | 42 ++++
 rtl/piso_ser.sv | 142 ++++++++++++++
 tb/tb_piso_ser.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/piso_ser_pkg.sv
// ----------------------------------------------------------------------------
// piso_ser_pkg
//   Items shared by piso_ser and the blocks around it: the FSM state
//   encoding (IDLE=0, SHIFT=1) and the default parallel word width.
// ----------------------------------------------------------------------------
package piso_ser_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      S_IDLE  = 1'b0,   // nothing shifting
      S_SHIFT = 1'b1    // a word is on its way out of the shifter
   } piso_state_e;

endpackage

// File: rtl/piso_ser_if.sv
// ----------------------------------------------------------------------------
// piso_ser_if
//   Bundles the parallel input handshake and the serial output of piso_ser.
//
//   Handshake (din side): a word moves on a rising clk edge where
//   din_vld=1 and din_rdy=1. din_rdy never depends on din_vld, so the
//   upstream may hold din_vld high while din_rdy is low; din is only
//   sampled on an edge where both are high.
//
//   Signals
//     din        parallel word                      (master -> slave)
//     din_vld    din holds a valid word             (master -> slave)
//     din_rdy    serializer accepts a word          (slave  -> master)
//     dout       serial bit, registered             (slave  -> master)
//     dout_vld   dout carries a payload bit         (slave  -> master)
//     busy       a word is shifting or buffered     (slave  -> master)
//     dbg_state  current FSM state, for observation (slave  -> master)
// ----------------------------------------------------------------------------
interface piso_ser_if #(
   parameter int WIDTH = piso_ser_pkg::DEFAULT_WIDTH
);
   import piso_ser_pkg::*;

   logic [WIDTH-1:0] din;
   logic             din_vld;
   logic             din_rdy;
   logic             dout;
   logic             dout_vld;
   logic             busy;
   piso_state_e      dbg_state;

   modport master (
      output din, din_vld,
      input  din_rdy, dout, dout_vld, busy, dbg_state
   );

   modport slave (
      input  din, din_vld,
      output din_rdy, dout, dout_vld, busy, dbg_state
   );

endinterface

// File: rtl/piso_ser.sv
// ----------------------------------------------------------------------------
// piso_ser
//   Parallel-in / serial-out converter with a one-entry holding register,
//   so consecutive words stream out with no idle bit between them.
//
//   Parameters
//     WIDTH      parallel word width, 2..32
//     MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     bus        piso_ser_if slave modport (din/din_vld/din_rdy in,
//                dout/dout_vld/busy/dbg_state out)
//
//   Latency: a word accepted on edge N shows its first bit on dout in the
//   cycle after edge N. dout_vld is high for exactly WIDTH cycles per word.
// ----------------------------------------------------------------------------
module piso_ser
   import piso_ser_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MSB_FIRST = 1
) (
   input  logic         clk,
   input  logic         rst,
   piso_ser_if.slave    bus
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   piso_state_e      state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_vld_q, hold_vld_d;
   logic             dout_q, dout_d;
   logic             dout_vld_q, dout_vld_d;

   logic             din_rdy;
   logic             xfer;

   // Bit that leaves first from a word in the shifter.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   // Shifter contents after its leading bit has been sent.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
   endfunction

   // Ready only looks at the holding register: while the shifter is busy an
   // arriving word parks in hold, and at the last bit the shifter reloads
   // from hold (or straight from din if hold is empty).
   assign din_rdy = !hold_vld_q && !rst;
   assign xfer    = bus.din_vld && din_rdy;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      dout_d     = 1'b0;
      dout_vld_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               state_d    = S_SHIFT;
               cnt_d      = '0;
               dout_d     = first_bit(bus.din);
               dout_vld_d = 1'b1;
               sh_d       = advance(bus.din);
            end
         end

         S_SHIFT: begin
            if (cnt_q == LAST) begin
               // Last bit of the current word is on dout now.
               if (hold_vld_q) begin
                  cnt_d      = '0;
                  dout_d     = first_bit(hold_q);
                  dout_vld_d = 1'b1;
                  sh_d       = advance(hold_q);
                  hold_vld_d = 1'b0;
               end else if (xfer) begin
                  cnt_d      = '0;
                  dout_d     = first_bit(bus.din);
                  dout_vld_d = 1'b1;
                  sh_d       = advance(bus.din);
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d      = cnt_q + CW'(1);
               dout_d     = first_bit(sh_q);
               dout_vld_d = 1'b1;
               sh_d       = advance(sh_q);
               if (xfer) begin
                  hold_d     = bus.din;
                  hold_vld_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sh_q       <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         dout_q     <= 1'b0;
         dout_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
      end
   end

   assign bus.din_rdy   = din_rdy;
   assign bus.dout      = dout_q;
   assign bus.dout_vld  = dout_vld_q;
   assign bus.busy      = (state_q == S_SHIFT) || hold_vld_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_piso_ser.sv
// ----------------------------------------------------------------------------
// tb_piso_ser
//   Directed bench for piso_ser: one MSB-first and one LSB-first instance,
//   both WIDTH=8. Inputs change 1 time unit after a rising edge and outputs
//   are sampled at that same point, i.e. away from the edge.
// ----------------------------------------------------------------------------
module tb_piso_ser;
   import piso_ser_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   piso_ser_if #(.WIDTH(8)) m_if ();
   piso_ser_if #(.WIDTH(8)) l_if ();

   piso_ser #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
      .clk (clk),
      .rst (rst),
      .bus (m_if)
   );

   piso_ser #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
      .clk (clk),
      .rst (rst),
      .bus (l_if)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [23:0] stream3;
   logic [15:0] stream2;
   logic [7:0]  w8;
   logic [3:0]  win;
   logic        exp_rdy;
   logic        exp_m4;
   logic        exp_m3;

   initial begin
      m_if.din = '0; m_if.din_vld = 1'b0;
      l_if.din = '0; l_if.din_vld = 1'b0;

      // ---------------- reset state ----------------
      rst = 1'b1;
      m_if.din_vld = 1'b1;           // must be ignored during reset
      m_if.din     = 8'hFF;
      step(); step();
      chk("rst_rdy",   32'(m_if.din_rdy),   32'd0);
      chk("rst_busy",  32'(m_if.busy),      32'd0);
      chk("rst_dout",  32'(m_if.dout),      32'd0);
      chk("rst_vld",   32'(m_if.dout_vld),  32'd0);
      chk("rst_state", 32'(m_if.dbg_state), 32'(S_IDLE));
      chk("rst_lrdy",  32'(l_if.din_rdy),   32'd0);
      m_if.din_vld = 1'b0;
      rst = 1'b0;
      step();
      chk("post_rst_rdy", 32'(m_if.din_rdy), 32'd1);
      chk("post_rst_vld", 32'(m_if.dout_vld), 32'd0);

      // ---------------- single word A5, MSB first ----------------
      w8 = 8'hA5;
      m_if.din = w8; m_if.din_vld = 1'b1;
      step();
      m_if.din_vld = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         chk("a5_bit", 32'(m_if.dout), 32'(w8[8-c]));
         chk("a5_vld", 32'(m_if.dout_vld), 32'd1);
         step();
      end
      chk("a5_end_vld",  32'(m_if.dout_vld),  32'd0);
      chk("a5_end_dout", 32'(m_if.dout),      32'd0);
      chk("a5_end_busy", 32'(m_if.busy),      32'd0);
      chk("a5_end_st",   32'(m_if.dbg_state), 32'(S_IDLE));

      // ---------------- back-to-back 05, 22, then FF under backpressure ---
      stream3 = {8'h05, 8'h22, 8'hFF};
      m_if.din = 8'h05; m_if.din_vld = 1'b1;
      step();
      for (int c = 1; c <= 25; c++) begin
         if (c == 1)  m_if.din = 8'h22;
         if (c == 2)  m_if.din = 8'hFF;
         if (c == 10) m_if.din_vld = 1'b0;   // FF accepted at the end of cycle 9
         exp_rdy = ((c >= 2 && c <= 8) || (c >= 10 && c <= 16)) ? 1'b0 : 1'b1;
         chk("b2b_rdy", 32'(m_if.din_rdy), 32'(exp_rdy));
         if (c <= 24) begin
            chk("b2b_bit",  32'(m_if.dout),     32'(stream3[24-c]));
            chk("b2b_vld",  32'(m_if.dout_vld), 32'd1);
            chk("b2b_busy", 32'(m_if.busy),     32'd1);
         end else begin
            chk("b2b_end_vld",  32'(m_if.dout_vld), 32'd0);
            chk("b2b_end_dout", 32'(m_if.dout),     32'd0);
            chk("b2b_end_busy", 32'(m_if.busy),     32'd0);
         end
         step();
      end

      // ---------------- LSB first: 01, then 96 loaded on the last bit -----
      stream2 = {8'h96, 8'h01};
      l_if.din = 8'h01; l_if.din_vld = 1'b1;
      step();
      l_if.din_vld = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         if (c == 8) begin
            l_if.din = 8'h96; l_if.din_vld = 1'b1;
            chk("lsb_rdy_last", 32'(l_if.din_rdy), 32'd1);
         end
         if (c == 9) l_if.din_vld = 1'b0;
         if (c <= 16) begin
            chk("lsb_bit", 32'(l_if.dout),     32'(stream2[c-1]));
            chk("lsb_vld", 32'(l_if.dout_vld), 32'd1);
         end else begin
            chk("lsb_end_vld", 32'(l_if.dout_vld), 32'd0);
            chk("lsb_end_st",  32'(l_if.dbg_state), 32'(S_IDLE));
         end
         step();
      end

      // ---------------- reset mid-word with a buffered word ----------------
      w8 = 8'hA5;
      m_if.din = w8; m_if.din_vld = 1'b1;
      step();
      m_if.din = 8'h3C;                       // goes to hold at end of cycle 1
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) m_if.din_vld = 1'b0;
         chk("rmw_bit", 32'(m_if.dout), 32'(w8[8-c]));
         if (c < 4) step();
      end
      chk("rmw_hold_rdy", 32'(m_if.din_rdy), 32'd0);
      chk("rmw_busy",     32'(m_if.busy),    32'd1);
      rst = 1'b1;
      m_if.din_vld = 1'b1;
      step();
      chk("rmw_vld",  32'(m_if.dout_vld), 32'd0);
      chk("rmw_dout", 32'(m_if.dout),     32'd0);
      chk("rmw_busy0", 32'(m_if.busy),    32'd0);
      chk("rmw_rdy0", 32'(m_if.din_rdy),  32'd0);
      m_if.din_vld = 1'b0;
      rst = 1'b0;
      step();
      chk("rmw_rdy1", 32'(m_if.din_rdy), 32'd1);
      for (int c = 0; c < 10; c++) begin
         chk("rmw_quiet", 32'(m_if.dout_vld), 32'd0);
         step();
      end

      // ---------------- end to end: 2D into a small pattern watcher -------
      // Stream 0,0,1,0,1,1,0,1: "0010" ends on bit 4, "101" on bits 5 and 8.
      win = 4'b0000;
      m_if.din = 8'h2D; m_if.din_vld = 1'b1;
      step();
      m_if.din_vld = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (m_if.dout_vld) win = {win[2:0], m_if.dout};
         exp_m4 = (c == 4);
         exp_m3 = (c == 5) || (c == 8);
         chk("e2e_vld",  32'(m_if.dout_vld),      32'd1);
         chk("e2e_0010", 32'(win == 4'b0010),     32'(exp_m4));
         chk("e2e_101",  32'(win[2:0] == 3'b101), 32'(exp_m3));
         step();
      end
      chk("e2e_end_vld", 32'(m_if.dout_vld), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
